// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode field values, default bubble word and the
// fetch FSM state encoding.
package cpu_defs;

  localparam logic [3:0]  OP_ADD = 4'h0;
  localparam logic [3:0]  OP_LLB = 4'hA;
  localparam logic [3:0]  OP_BR  = 4'hC;
  localparam logic [3:0]  OP_PCS = 4'hE;
  localparam logic [3:0]  OP_HLT = 4'hF;

  localparam logic [15:0] DEF_BUBBLE_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  function automatic logic is_hlt(input logic [15:0] instr);
    return instr[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise it
// loads the new instruction or drops to a bubble.
module ifid_reg import cpu_defs::*; #(
  parameter logic [15:0] BUBBLE_INSTR = DEF_BUBBLE_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        load,
  input  logic [15:0] new_instr,
  input  logic [15:0] new_pc_plus2,
  output logic        valid,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= BUBBLE_INSTR;
      pc_plus2 <= 16'h0000;
    end else if (flush || (!stall && !load)) begin
      valid <= 1'b0;
      instr <= BUBBLE_INSTR;
    end else if (!stall) begin
      valid    <= 1'b1;
      instr    <= new_instr;
      pc_plus2 <= new_pc_plus2;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM, one-entry skid
// for responses that land under stall, and the IF/ID register.
module fetch_stage import cpu_defs::*; #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = DEF_BUBBLE_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc,
  output logic        ifid_valid,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        halted
);

  fetch_state_e state;
  logic [15:0]  skid;
  logic [15:0]  pc_plus2;
  logic [15:0]  new_instr;
  logic         squash;
  logic         deliver;

  assign imem_addr = pc;
  assign pc_plus2  = pc + 16'd2;
  assign new_instr = (state == ST_HOLD) ? skid : imem_data;
  assign deliver   = !redirect && !stall &&
                     ((state == ST_HOLD) || (state == ST_WAIT && imem_valid && !squash));

  // imem_req is registered: it is raised on the edge that enters REQ, so the
  // first REQ cycle after reset is spent arming it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
      skid     <= BUBBLE_INSTR;
      squash   <= 1'b0;
      halted   <= 1'b0;
    end else if (redirect) begin
      pc     <= redirect_pc;
      skid   <= BUBBLE_INSTR;
      halted <= 1'b0;
      // A request on the bus now (or still unanswered) must be drained first,
      // otherwise two requests would be outstanding.
      if ((state == ST_WAIT && !imem_valid) || (state == ST_REQ && imem_req)) begin
        state    <= ST_WAIT;
        squash   <= 1'b1;
        imem_req <= 1'b0;
      end else begin
        state    <= ST_REQ;
        squash   <= 1'b0;
        imem_req <= 1'b1;
      end
    end else if (deliver) begin
      skid <= BUBBLE_INSTR;
      if (is_hlt(new_instr)) begin
        state    <= ST_HALT;
        halted   <= 1'b1;
        imem_req <= 1'b0;
      end else begin
        pc       <= pc_plus2;
        state    <= ST_REQ;
        imem_req <= 1'b1;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (imem_req) begin
            imem_req <= 1'b0;
            state    <= ST_WAIT;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_valid && squash) begin
            squash   <= 1'b0;
            state    <= ST_REQ;
            imem_req <= 1'b1;
          end else if (imem_valid) begin
            skid  <= imem_data;
            state <= ST_HOLD;
          end
        end
        default: ;
      endcase
    end
  end

  ifid_reg #(.BUBBLE_INSTR(BUBBLE_INSTR)) u_ifid (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (redirect),
    .load         (deliver),
    .new_instr    (new_instr),
    .new_pc_plus2 (pc_plus2),
    .valid        (ifid_valid),
    .instr        (ifid_instr),
    .pc_plus2     (ifid_pc_plus2)
  );

endmodule
